pwm_breathe_sequencer: RTL and testbench

//   Controller that sequences one downstream N-bit PWM channel through a "breathing" fade.
//   - Generates the PWM step strobe from a clock prescaler.
//   - Ramps duty min->max->min one LSB per PWM period, holding at each end.
//   - Drives the channel enable and a counter-align pulse, repeating for a set number of cycles.
//   - Sits between the control/register logic and a PWM instance (clk/rst/ena/step/duty).
//

---
 rtl/pwm_breathe_sequencer_if.sv | 32 +++
 rtl/pwm_breathe_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pwm_breathe_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_breathe_sequencer_if.sv
// Control/status and PWM-channel bundle between the register logic, the breathe
// sequencer and the PWM instance it drives.
interface pwm_breathe_sequencer_if #(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16,
  parameter int HOLD_W     = 8,
  parameter int CYCLE_W    = 8
);
  logic                  start;
  logic                  stop;
  logic [PRESCALE_W-1:0] prescale;
  logic [N-1:0]          duty_min;
  logic [N-1:0]          duty_max;
  logic [HOLD_W-1:0]     hold_periods;
  logic [CYCLE_W-1:0]    cycles;
  logic                  pwm_step;
  logic                  pwm_ena;
  logic [N-1:0]          pwm_duty;
  logic                  pwm_sync;
  logic                  busy;
  logic                  done;

  modport master (
    output start, stop, prescale, duty_min, duty_max, hold_periods, cycles,
    input  pwm_step, pwm_ena, pwm_duty, pwm_sync, busy, done
  );

  modport slave (
    input  start, stop, prescale, duty_min, duty_max, hold_periods, cycles,
    output pwm_step, pwm_ena, pwm_duty, pwm_sync, busy, done
  );
endinterface

// File: rtl/pwm_breathe_sequencer.sv
// Sequences one PWM channel through a min->max->min "breathing" fade, one LSB per
// PWM period, with programmable end holds and a finite or endless cycle count.
module pwm_breathe_sequencer #(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16,
  parameter int HOLD_W     = 8,
  parameter int CYCLE_W    = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  pwm_breathe_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_UP      = 3'd2,
    ST_HOLD_HI = 3'd3,
    ST_DOWN    = 3'd4,
    ST_HOLD_LO = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [PRESCALE_W-1:0] prescale_r, prescale_s, psc_cnt_r, psc_cnt_s;
  logic [N-1:0]          min_r, min_s, max_r, max_s, duty_r, duty_s, per_cnt_r, per_cnt_s;
  logic [HOLD_W-1:0]     hold_r, hold_s, hold_cnt_r, hold_cnt_s;
  logic [CYCLE_W-1:0]    cycles_r, cycles_s, cyc_cnt_r, cyc_cnt_s, cyc_inc_s;
  logic                  step_r, step_s, ena_r, ena_s, sync_r, sync_s;
  logic                  busy_r, busy_s, done_r, done_s;
  logic                  per_end_s, stop_s, finish_s, run_s, run_now_s;

  assign per_end_s = step_r && (per_cnt_r == {N{1'b1}});
  assign stop_s    = bus.stop && (state_r != ST_IDLE);
  assign cyc_inc_s = cyc_cnt_r + CYCLE_W'(1);

  // Next-state, latched configuration and duty ramp.
  always_comb begin
    state_s    = state_r;
    prescale_s = prescale_r;
    min_s      = min_r;
    max_s      = max_r;
    hold_s     = hold_r;
    cycles_s   = cycles_r;
    duty_s     = duty_r;
    ena_s      = ena_r;
    hold_cnt_s = hold_cnt_r;
    cyc_cnt_s  = cyc_cnt_r;
    sync_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_s    = ST_SYNC;
          prescale_s = bus.prescale;
          min_s      = bus.duty_min;
          max_s      = (bus.duty_min > bus.duty_max) ? bus.duty_min : bus.duty_max;
          hold_s     = bus.hold_periods;
          cycles_s   = bus.cycles;
          duty_s     = bus.duty_min;
          ena_s      = 1'b1;
          sync_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        state_s = ST_UP;
      end
      ST_UP: begin
        if (per_end_s && (duty_r == max_r)) begin
          state_s    = ST_HOLD_HI;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else if (per_end_s) begin
          duty_s = duty_r + N'(1);
        end else begin
          duty_s = duty_r;
        end
      end
      ST_HOLD_HI: begin
        // Leaving a hold takes the first ramp step at once, so the end value is
        // seen only in the ramp's last period and the hold periods.
        if (per_end_s && (hold_cnt_r == hold_r)) begin
          state_s    = ST_DOWN;
          hold_cnt_s = {HOLD_W{1'b0}};
          duty_s     = (duty_r > min_r) ? (duty_r - N'(1)) : duty_r;
        end else if (per_end_s) begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      ST_DOWN: begin
        if (per_end_s && (duty_r == min_r)) begin
          state_s    = ST_HOLD_LO;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else if (per_end_s) begin
          duty_s = duty_r - N'(1);
        end else begin
          duty_s = duty_r;
        end
      end
      ST_HOLD_LO: begin
        if (per_end_s && (hold_cnt_r == hold_r)) begin
          cyc_cnt_s  = cyc_inc_s;
          hold_cnt_s = {HOLD_W{1'b0}};
          if ((cycles_r != {CYCLE_W{1'b0}}) && (cyc_inc_s == cycles_r)) begin
            finish_s = 1'b1;
          end else begin
            state_s = ST_UP;
            duty_s  = (duty_r < max_r) ? (duty_r + N'(1)) : duty_r;
          end
        end else if (per_end_s) begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    done_s = finish_s && !stop_s;
    if (stop_s || finish_s) begin
      state_s    = ST_IDLE;
      duty_s     = {N{1'b0}};
      ena_s      = 1'b0;
      hold_cnt_s = {HOLD_W{1'b0}};
      cyc_cnt_s  = {CYCLE_W{1'b0}};
    end else begin
      sync_s = sync_s;
    end
    busy_s = (state_s != ST_IDLE);
  end

  // Prescaler and period tracker; both sit at 0 outside the ramp/hold states.
  always_comb begin
    run_now_s = (state_r == ST_UP) || (state_r == ST_HOLD_HI) ||
                (state_r == ST_DOWN) || (state_r == ST_HOLD_LO);
    run_s     = (state_s == ST_UP) || (state_s == ST_HOLD_HI) ||
                (state_s == ST_DOWN) || (state_s == ST_HOLD_LO);
    psc_cnt_s = {PRESCALE_W{1'b0}};
    per_cnt_s = {N{1'b0}};
    if (run_s && run_now_s) begin
      psc_cnt_s = step_r ? {PRESCALE_W{1'b0}} : (psc_cnt_r + PRESCALE_W'(1));
      per_cnt_s = step_r ? (per_cnt_r + N'(1)) : per_cnt_r;
    end else begin
      psc_cnt_s = {PRESCALE_W{1'b0}};
    end
    step_s = run_s && (psc_cnt_s == prescale_s);
  end

  // State, configuration, counters and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      prescale_r <= {PRESCALE_W{1'b0}};
      psc_cnt_r  <= {PRESCALE_W{1'b0}};
      min_r      <= {N{1'b0}};
      max_r      <= {N{1'b0}};
      duty_r     <= {N{1'b0}};
      per_cnt_r  <= {N{1'b0}};
      hold_r     <= {HOLD_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      cycles_r   <= {CYCLE_W{1'b0}};
      cyc_cnt_r  <= {CYCLE_W{1'b0}};
      step_r     <= 1'b0;
      ena_r      <= 1'b0;
      sync_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      prescale_r <= prescale_s;
      psc_cnt_r  <= psc_cnt_s;
      min_r      <= min_s;
      max_r      <= max_s;
      duty_r     <= duty_s;
      per_cnt_r  <= per_cnt_s;
      hold_r     <= hold_s;
      hold_cnt_r <= hold_cnt_s;
      cycles_r   <= cycles_s;
      cyc_cnt_r  <= cyc_cnt_s;
      step_r     <= step_s;
      ena_r      <= ena_s;
      sync_r     <= sync_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.pwm_step = step_r;
  assign bus.pwm_ena  = ena_r;
  assign bus.pwm_duty = duty_r;
  assign bus.pwm_sync = sync_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_pwm_breathe_sequencer.sv
// Directed bench for pwm_breathe_sequencer: reset, step timing, fade profile,
// holds with a flat fade, endless runs with stop, and start while busy.
module tb_pwm_breathe_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   t0 = 0;
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   fade_tab [11] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
  int   loop_tab [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};

  pwm_breathe_sequencer_if #(.N(8), .PRESCALE_W(16), .HOLD_W(8), .CYCLE_W(8)) bus ();

  pwm_breathe_sequencer #(.N(8), .PRESCALE_W(16), .HOLD_W(8), .CYCLE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  task automatic wait_off(input int off);
    while (cyc - t0 < off) @(negedge clk);
  endtask

  task automatic start_run(input int psc, input int mn, input int mx, input int hold, input int cy);
    bus.prescale     = 16'(psc);
    bus.duty_min     = 8'(mn);
    bus.duty_max     = 8'(mx);
    bus.hold_periods = 8'(hold);
    bus.cycles       = 8'(cy);
    bus.start        = 1'b1;
    t0               = cyc;
    @(negedge clk);
    bus.start        = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    bus.start = 1'b0; bus.stop = 1'b0; bus.prescale = 16'd0; bus.duty_min = 8'd0;
    bus.duty_max = 8'd0; bus.hold_periods = 8'd0; bus.cycles = 8'd0;
    repeat (3) @(negedge clk);
    obs = {bus.pwm_step, bus.pwm_ena, bus.pwm_duty, bus.pwm_sync, bus.busy, bus.done};
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset_hold: got %h expected 0", obs); end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {bus.pwm_step, bus.pwm_ena, bus.pwm_duty, bus.pwm_sync, bus.busy, bus.done};
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset_release: got %h expected 0", obs); end
    start_run(0, 5, 10, 0, 0);
    wait_off(100);
    obs = {bus.pwm_step, bus.pwm_ena, bus.pwm_duty, bus.pwm_sync, bus.busy, bus.done};
    checks++;
    if (obs !== {1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_up_state: got %h expected %h", obs, {1'b1, 1'b1, 8'd5, 3'b010});
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.pwm_step, bus.pwm_ena, bus.pwm_duty, bus.pwm_sync, bus.busy, bus.done};
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs = {bus.pwm_step, bus.pwm_ena, bus.pwm_duty, bus.pwm_sync, bus.busy, bus.done};
    checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL after_async_reset: got %h expected 0", obs); end
  endtask

  task automatic test_step_timing();
    logic exp_step;
    start_run(3, 0, 4, 0, 1);
    checks++;
    if ({bus.pwm_sync, bus.busy, bus.pwm_step, bus.pwm_ena, bus.pwm_duty} !== {4'b1101, 8'd0}) begin
      errors++;
      $display("FAIL sync_cycle: sync=%b busy=%b step=%b ena=%b duty=%0d expected 1 1 0 1 0",
               bus.pwm_sync, bus.busy, bus.pwm_step, bus.pwm_ena, bus.pwm_duty);
    end
    for (int off = 2; off <= 14; off++) begin
      wait_off(off);
      exp_step = (off >= 5) && ((off - 5) % 4 == 0);
      checks++;
      if ({bus.pwm_step, bus.pwm_sync} !== {exp_step, 1'b0}) begin
        errors++;
        $display("FAIL step_timing@%0d: step=%b sync=%b expected %b 0", off, bus.pwm_step, bus.pwm_sync, exp_step);
      end
    end
  endtask

  task automatic test_fade();
    for (int i = 0; i < 11; i++) begin
      wait_off(500 + 1024 * i);
      checks++;
      if ({bus.pwm_ena, bus.pwm_duty} !== {1'b1, 8'(fade_tab[i])}) begin
        errors++;
        $display("FAIL fade_period%0d: ena=%b duty=%0d expected 1 %0d", i, bus.pwm_ena, bus.pwm_duty, fade_tab[i]);
      end
      if (i == 0) begin
        wait_off(1025);
        checks++;
        if (bus.pwm_duty !== 8'd0) begin errors++; $display("FAIL fade_edge_before: duty=%0d expected 0", bus.pwm_duty); end
        wait_off(1026);
        checks++;
        if (bus.pwm_duty !== 8'd1) begin errors++; $display("FAIL fade_edge_after: duty=%0d expected 1", bus.pwm_duty); end
      end
    end
    wait_off(11265);
    checks++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL fade_pre_done: done=%b busy=%b expected 0 1", bus.done, bus.busy);
    end
    wait_off(11266);
    checks++;
    if ({bus.done, bus.busy, bus.pwm_ena, bus.pwm_duty} !== {3'b100, 8'd0}) begin
      errors++;
      $display("FAIL fade_done: done=%b busy=%b ena=%b duty=%0d expected 1 0 0 0",
               bus.done, bus.busy, bus.pwm_ena, bus.pwm_duty);
    end
    wait_off(11267);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL fade_done_pulse: done=%b expected 0", bus.done); end
  endtask

  task automatic test_hold_flat();
    start_run(0, 9, 5, 2, 1);
    for (int p = 0; p < 8; p++) begin
      wait_off(100 + 256 * p);
      checks++;
      if (bus.pwm_duty !== 8'd9) begin errors++; $display("FAIL flat_duty_p%0d: duty=%0d expected 9", p, bus.pwm_duty); end
    end
    wait_off(2049);
    checks++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL hold_pre_done: done=%b busy=%b expected 0 1", bus.done, bus.busy);
    end
    wait_off(2050);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL hold_done: done=%b busy=%b expected 1 0", bus.done, bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_infinite_stop();
    int done_base;
    int exp;
    done_base = done_cnt;
    start_run(0, 0, 4, 0, 0);
    for (int p = 0; p < 45; p++) begin
      wait_off(100 + 256 * p);
      exp = (p < 11) ? fade_tab[p] : loop_tab[(p - 11) % 10];
      checks++;
      if (bus.pwm_duty !== 8'(exp)) begin errors++; $display("FAIL loop_duty_p%0d: duty=%0d expected %0d", p, bus.pwm_duty, exp); end
    end
    checks++;
    if ({bus.busy, 32'(done_cnt - done_base)} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL endless_run: busy=%b done_pulses=%0d expected 1 0", bus.busy, done_cnt - done_base);
    end
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++;
    if ({bus.busy, bus.pwm_ena, bus.pwm_duty, bus.done, bus.pwm_step} !== 12'd0) begin
      errors++;
      $display("FAIL stop_abort: busy=%b ena=%b duty=%0d done=%b step=%b expected all 0",
               bus.busy, bus.pwm_ena, bus.pwm_duty, bus.done, bus.pwm_step);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.pwm_sync, 32'(done_cnt - done_base)} !== {2'b00, 32'd0}) begin
      errors++;
      $display("FAIL stop_in_idle: busy=%b sync=%b done_pulses=%0d expected 0 0 0",
               bus.busy, bus.pwm_sync, done_cnt - done_base);
    end
    start_run(0, 2, 3, 0, 1);
    checks++;
    if ({bus.pwm_sync, bus.busy, bus.pwm_duty} !== {2'b11, 8'd2}) begin
      errors++; $display("FAIL restart: sync=%b busy=%b duty=%0d expected 1 1 2", bus.pwm_sync, bus.busy, bus.pwm_duty);
    end
    wait_off(1282);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL restart_done: done=%b busy=%b expected 1 0", bus.done, bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    start_run(0, 0, 4, 0, 1);
    wait_off(100 + 256 * 7);
    checks++;
    if (bus.pwm_duty !== 8'd2) begin errors++; $display("FAIL busy_pre: duty=%0d expected 2", bus.pwm_duty); end
    bus.duty_max = 8'd200; bus.prescale = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.pwm_sync} !== 2'b10) begin
      errors++; $display("FAIL busy_start_ignored: busy=%b sync=%b expected 1 0", bus.busy, bus.pwm_sync);
    end
    for (int p = 8; p < 11; p++) begin
      wait_off(100 + 256 * p);
      checks++;
      if (bus.pwm_duty !== 8'(fade_tab[p])) begin
        errors++; $display("FAIL busy_duty_p%0d: duty=%0d expected %0d", p, bus.pwm_duty, fade_tab[p]);
      end
    end
    wait_off(2817);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL busy_pre_done: done=%b expected 0", bus.done); end
    wait_off(2818);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL busy_done: done=%b busy=%b expected 1 0", bus.done, bus.busy);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_step_timing();
    test_fade();
    test_hold_flat();
    test_infinite_stop();
    test_busy_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
